// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and defaults for the SynsFIFO read-side stream master.
package fifo_stream_reader_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } rd_state_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Downstream valid/ready stream carrying words read out of the FIFO.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/fifo_stream_reader_rd_skid.sv
// Circular landing buffer that absorbs words returned by the FIFO's 1-cycle read latency.
module fifo_stream_reader_rd_skid
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned BUF_DEPTH = 4,
    localparam int unsigned PtrW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int unsigned OccW     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [OccW-1:0]   occ_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [OccW-1:0]   occ_q;

    // Explicit wrap so non-power-of-two depths stay legal.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + OccW'(1);
                2'b01:   occ_q <= occ_q - OccW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// SynsFIFO read-side master: credit-based rd_en, landing buffer, valid/ready output, flush.
// Define FIFO_RD_CNT_EN to add the rd_count delivered-word counter port.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [DATA_W-1:0]    fifo_dout,
    output logic                 fifo_rd_en,
    fifo_stream_reader_if.master m_if,
    output logic                 flush_done
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [31:0]          rd_count
`endif
);

    localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);

    rd_state_t         state_q;
    logic              inflight_q;
    logic              flush_done_q;
    logic              credit;
    logic              clr;
    logic              push;
    logic              pop;
    logic [OccW-1:0]   occ;
    logic [DATA_W-1:0] head;

    // Words already requested count against buffer space so a landing word always fits.
    assign credit = (32'(occ) + 32'(inflight_q)) < BUF_DEPTH;

    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst) begin
            case (state_q)
                StRun:   fifo_rd_en = !fifo_empty && credit;
                StFlush: fifo_rd_en = !fifo_empty;
                default: fifo_rd_en = 1'b0;
            endcase
        end
    end

    assign clr  = flush && (state_q != StFlush);
    assign push = inflight_q && (state_q != StFlush) && !clr;
    assign pop  = m_if.m_valid && m_if.m_ready;

    assign m_if.m_valid = (occ != '0);
    assign m_if.m_data  = m_if.m_valid ? head : '0;
    assign flush_done   = flush_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            inflight_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            inflight_q   <= fifo_rd_en;
            flush_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (flush) begin
                        state_q <= StFlush;
                    end else if (en) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (flush) begin
                        state_q <= StFlush;
                    end else if (!en) begin
                        state_q <= StIdle;
                    end
                end
                StFlush: begin
                    if (fifo_empty && !inflight_q && !fifo_rd_en) begin
                        state_q      <= StIdle;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fifo_stream_reader_rd_skid #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .push_i      (push),
        .push_data_i (fifo_dout),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

`ifdef FIFO_RD_CNT_EN
    logic [31:0] rd_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
        end else if (pop) begin
            rd_count_q <= rd_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural SynsFIFO model on the read side.
module tb_fifo_stream_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned BD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          flush_done;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
`ifdef FIFO_RD_CNT_EN
    logic [31:0]   rd_count;
`endif

    fifo_stream_reader_if #(.DATA_W(DW)) s_if ();

    assign m_valid      = s_if.m_valid;
    assign m_data       = s_if.m_data;
    assign s_if.m_ready = m_ready;

    fifo_stream_reader #(
        .DATA_W    (DW),
        .BUF_DEPTH (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_if       (s_if),
        .flush_done (flush_done)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // SynsFIFO model: dout valid one clock after rd_en is sampled.
    logic [DW-1:0] fmem [1024];
    int f_wr = 0;
    int f_rd = 0;
    int empty_reads = 0;

    assign fifo_empty = (f_wr == f_rd);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (f_wr == f_rd) begin
                empty_reads <= empty_reads + 1;
            end else begin
                fifo_dout <= fmem[f_rd % 1024];
                f_rd      <= f_rd + 1;
            end
        end
    end

    typedef struct {
        logic          en;
        logic          rdy;
        logic          rd;
        logic          vld;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vec[18];

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] got[$];
    int ncyc = 0;
    int first_hs = -1;
    int last_hs = -1;
    int rd_pulses = 0;
    int fd_pulses = 0;
    int vcount = 0;
    int bad_rd = 0;
    int hold_viol = 0;
    logic prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fmem[f_wr % 1024] = w;
        f_wr = f_wr + 1;
    endtask

    // Called at a negedge with inputs applied: sample, then advance one clock.
    task automatic step();
        #1;
        if (prev_hold && (!m_valid || m_data !== prev_data)) hold_viol++;
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            if (first_hs < 0) first_hs = ncyc;
            last_hs = ncyc;
        end
        if (m_valid) vcount++;
        if (fifo_rd_en) rd_pulses++;
        if (flush_done) fd_pulses++;
        if (fifo_rd_en && fifo_empty) bad_rd++;
        @(negedge clk);
        ncyc++;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        first_hs = -1;
        last_hs = -1;
        prev_hold = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int p;
        logic [31:0] cnt_before;

        // Backpressure trace: 10 words, consumer stalled for 7 cycles then always ready.
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vec[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vec[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA0};
        vec[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA0};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA0};
        vec[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA1};
        vec[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA2};
        vec[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA3};
        vec[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA4};
        vec[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA5};
        vec[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA6};
        vec[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA7};
        vec[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA8};
        vec[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA9};
        vec[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

        rst = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) load(8'hA0 + 8'(i));

        // Reset with a non-empty FIFO.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rst rd_en c%0d", i), 32'(fifo_rd_en), 32'd0);
            chk($sformatf("rst m_valid c%0d", i), 32'(m_valid), 32'd0);
            chk($sformatf("rst m_data c%0d", i), 32'(m_data), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;

        // Backpressure table.
        p = 0;
        for (int k = 0; k < 18; k++) begin
            en = vec[k].en;
            m_ready = vec[k].rdy;
            #1;
            chk($sformatf("bp rd_en k%0d", k), 32'(fifo_rd_en), 32'(vec[k].rd));
            chk($sformatf("bp m_valid k%0d", k), 32'(m_valid), 32'(vec[k].vld));
            chk($sformatf("bp m_data k%0d", k), 32'(m_data), 32'(vec[k].data));
            if (k < 7 && fifo_rd_en) p++;
            @(negedge clk);
        end
        chk("bp rd_en pulses while stalled", 32'(p), 32'd4);

        // Full-rate streaming of 64 words.
        reset_dut();
        base = f_wr;
        for (int i = 0; i < 64; i++) load(8'(i));
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 300 && got.size() < 64; i++) step();
        chk("stream word count", 32'(got.size()), 32'd64);
        for (int i = 0; i < 64 && i < got.size(); i++)
            chk($sformatf("stream word %0d", i), 32'(got[i]), 32'(fmem[(base + i) % 1024]));
        chk("stream one word per clk", 32'(last_hs - first_hs), 32'd63);
`ifdef FIFO_RD_CNT_EN
        chk("stream rd_count", rd_count, 32'd64);
`endif

        // Random backpressure over 200 words.
        reset_dut();
        base = f_wr;
        for (int i = 0; i < 200; i++) load(8'($urandom_range(0, 255)));
        en = 1'b1;
        hold_viol = 0;
        for (int i = 0; i < 3000 && got.size() < 200; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("random word count", 32'(got.size()), 32'd200);
        for (int i = 0; i < 200 && i < got.size(); i++)
            chk($sformatf("random word %0d", i), 32'(got[i]), 32'(fmem[(base + i) % 1024]));
        chk("random m_data hold under stall", 32'(hold_viol), 32'd0);

        // Flush with 3 buffered words and 20 in the FIFO.
        reset_dut();
        for (int i = 0; i < 3; i++) load(8'hB0 + 8'(i));
        en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("flush pre m_valid", 32'(m_valid), 32'd1);
        chk("flush pre m_data", 32'(m_data), 32'hB0);
        en = 1'b0;
        step();
        for (int i = 0; i < 20; i++) load(8'hC0 + 8'(i));
        step();
`ifdef FIFO_RD_CNT_EN
        cnt_before = rd_count;
`else
        cnt_before = 32'd0;
`endif
        fd_pulses = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("flush m_valid next clk", 32'(m_valid), 32'd0);
        vcount = 0;
        got.delete();
        for (int i = 0; i < 60; i++) step();
        chk("flush done pulses", 32'(fd_pulses), 32'd1);
        chk("flush m_valid during drain", 32'(vcount), 32'd0);
        chk("flush words delivered", 32'(got.size()), 32'd0);
        chk("flush fifo drained", 32'(f_wr - f_rd), 32'd0);
`ifdef FIFO_RD_CNT_EN
        chk("flush rd_count unchanged", rd_count, cnt_before);
`else
        chk("flush rd_en low after drain", 32'(fifo_rd_en), cnt_before);
`endif
        load(8'h77);
        rd_pulses = 0;
        for (int i = 0; i < 3; i++) step();
        chk("flush back to idle", 32'(rd_pulses), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 20 && got.size() < 1; i++) step();
        chk("post flush word count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("post flush word", 32'(got[0]), 32'h77);

        // Reset while a word is landing and two are buffered.
        reset_dut();
        for (int i = 0; i < 5; i++) load(8'hD0 + 8'(i));
        en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rst mid pre m_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        step();
        #1;
        chk("rst mid m_valid", 32'(m_valid), 32'd0);
        chk("rst mid m_data", 32'(m_data), 32'd0);
        rst = 1'b0;
        en = 1'b0;
        @(negedge clk);
        vcount = 0;
        for (int i = 0; i < 3; i++) step();
        chk("rst mid landing dropped", 32'(vcount), 32'd0);
        en = 1'b1;
        m_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 30 && got.size() < 2; i++) step();
        chk("rst mid resume count", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            chk("rst mid resume word0", 32'(got[0]), 32'hD3);
            chk("rst mid resume word1", 32'(got[1]), 32'hD4);
        end

        chk("no rd_en while empty", 32'(bad_rd), 32'd0);
        chk("no model empty reads", 32'(empty_reads), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
